spi_master_ctrl: RTL and testbench
==================================

// Module: spi_master_ctrl
// PURPOSE
//  SPI frame initiator for the SPI slave + RAM subsystem; drives SS_n/MOSI and samples MISO on the
//  shared system clock (no separate SCLK). Serialises one host command per frame: mode bit, then
//  10-bit word {op[1:0],data[7:0]}. For read-data (op=2'b11) it captures the 8-bit MISO reply.
//  Sits on the bench/host side as the counterpart that exercises the slave wrapper.
// PARAMETERS
//  TURNAROUND  2  cycles between last MOSI bit and first MISO sample (slave RAM + load latency)
//  GAP         1  minimum cycles SS_n held high between frames
//  RD_BITS     8  MISO bits captured for op=2'b11
// PORTS
//  clk        in   1  system clock, all logic on rising edge
//  rst        in   1  asynchronous, active-high reset
//  cmd_valid  in   1  host command request
//  cmd_ready  out  1  controller can accept a command
//  cmd_op     in   2  00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data
//  cmd_data   in   8  address or data byte
//  resp_valid out  1  one-cycle pulse: resp_data valid (op=11 only)
//  resp_data  out  8  byte captured from MISO, MSB first
//  busy       out  1  frame in progress (SS_n low or gap running)
//  SS_n       out  1  slave select, active low
//  MOSI       out  1  serial data to slave
//  MISO       in   1  serial data from slave
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-high.
//  Reset: SS_n=1, MOSI=0, cmd_ready=0 in reset then 1 once GAP cycles elapse, resp_valid=0,
//   resp_data=0, busy=1 until gap done; state=IDLE.
//  Handshake: accept when cmd_valid&&cmd_ready; op/data registered; cmd_ready=0 until frame+gap done.
//  FSM (one state per cycle unless counted):
//   IDLE   : SS_n=1; on accept -> SEL.
//   SEL    : SS_n=0, MOSI=0 (slave leaves idle) -> MODE.
//   MODE   : MOSI=op[1] (0 write, 1 read) -> SHIFT.
//   SHIFT  : 10 cycles, MOSI = {op,data}[9..0] MSB first; after bit 0: op=11 -> WAIT, else -> END.
//   WAIT   : TURNAROUND cycles, MOSI=0 -> RECV.
//   RECV   : RD_BITS cycles; MISO shifted into LSB of shift reg each rising edge -> END.
//   END    : SS_n=1, MOSI=0; if op=11 resp_valid=1, resp_data=shift reg (this cycle only) -> GAP.
//   GAP    : SS_n=1 for GAP-1 further cycles (GAP=1 => none) -> IDLE.
//  Frame length (SS_n low): 12 cycles for op 00/01/10; 12+TURNAROUND+RD_BITS for op 11.
//  cmd_valid ignored while busy; cmd_op/cmd_data changes mid-frame have no effect.
//  rd-addr then rd-data ordering is the host's job; controller does not check or reorder.
//  rst mid-frame: SS_n to 1 asynchronously, frame dropped, no resp_valid; slave resyncs on SS_n high.
//  Back-to-back: cmd_valid held high -> next SEL exactly GAP cycles after END.
//  MISO ignored in all states except RECV.
// TESTING
//  T1 wr-addr op=00,data=8'hA5 -> SS_n low 12 cycles, MOSI seq 0,0,0,0,1,0,1,0,0,1,0,1; no resp.
//  T2 wr-data 01/8'h3C after T1, then rd-addr 10/A5, rd-data 11/xx -> resp_valid once, resp_data=8'h3C
//     (slave RAM model), SS_n low 22 cycles with defaults.
//  T3 cmd_valid held high over 3 commands -> exactly GAP=1 SS_n-high cycle between frames, 3 accepts.
//  T4 rst pulsed at SHIFT bit 5 of op=11 -> SS_n=1 same cycle, no resp_valid, next command correct.
//  T5 cmd_op/cmd_data toggled every cycle mid-frame -> MOSI pattern unchanged from accepted values.
//  T6 TURNAROUND=4, MISO driven 8'h81 aligned to RECV -> resp_data=8'h81; MISO toggles outside RECV ignored.

Source files
------------

// File: rtl/spi_master_ctrl.sv
// SPI frame initiator on the shared system clock: mode bit + {op,data} out on MOSI,
// optional read reply captured from MISO after a fixed turnaround.
module spi_master_ctrl #(
    parameter int TURNAROUND = 2,
    parameter int GAP        = 1,   // must be >= 1
    parameter int RD_BITS    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [7:0]         cmd_data,
    output logic               resp_valid,
    output logic [RD_BITS-1:0] resp_data,
    output logic               busy,
    output logic               SS_n,
    output logic               MOSI,
    input  logic               MISO
);

    localparam int WORD  = 10;
    localparam int SW    = (RD_BITS > WORD) ? RD_BITS : WORD;
    localparam int CMAX0 = (TURNAROUND > WORD) ? TURNAROUND : WORD;
    localparam int CMAX1 = (RD_BITS > CMAX0) ? RD_BITS : CMAX0;
    localparam int CMAX  = (GAP > CMAX1) ? GAP : CMAX1;
    localparam int CW    = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SEL, S_MODE, S_SHIFT, S_WAIT, S_RECV, S_END, S_GAP
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [1:0]      op_q;
    logic [SW-1:0]   sreg;
    logic            accept;
    logic            is_rd;

    assign is_rd  = (op_q == 2'b11);
    assign accept = cmd_ready && cmd_valid;
    assign busy   = !cmd_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= CW'(GAP);   // IDLE drains this before the first accept
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Word is left-aligned so SHIFT always emits the MSB; MISO enters at the LSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q <= 2'b00;
            sreg <= '0;
        end else if (accept) begin
            op_q <= cmd_op;
            sreg <= SW'({cmd_op, cmd_data}) << (SW - WORD);
        end else if (state == S_SHIFT) begin
            sreg <= {sreg[SW-2:0], 1'b0};
        end else if (state == S_RECV) begin
            sreg <= {sreg[SW-2:0], MISO};
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        cmd_ready  = 1'b0;
        SS_n       = 1'b1;
        MOSI       = 1'b0;
        resp_valid = 1'b0;
        resp_data  = '0;
        case (state)
            S_IDLE: begin
                cmd_ready = (cnt == '0);
                if (cnt != '0) cnt_nxt = cnt - CW'(1);
                if (cmd_ready && cmd_valid) state_nxt = S_SEL;
            end
            S_SEL: begin
                SS_n      = 1'b0;
                state_nxt = S_MODE;
            end
            S_MODE: begin
                SS_n      = 1'b0;
                MOSI      = op_q[1];
                cnt_nxt   = CW'(WORD - 1);
                state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                SS_n = 1'b0;
                MOSI = sreg[SW-1];
                if (cnt != '0) begin
                    cnt_nxt = cnt - CW'(1);
                end else if (!is_rd) begin
                    state_nxt = S_END;
                end else if (TURNAROUND > 0) begin
                    cnt_nxt   = CW'(TURNAROUND > 0 ? TURNAROUND - 1 : 0);
                    state_nxt = S_WAIT;
                end else begin
                    cnt_nxt   = CW'(RD_BITS - 1);
                    state_nxt = S_RECV;
                end
            end
            S_WAIT: begin
                SS_n = 1'b0;
                if (cnt != '0) begin
                    cnt_nxt = cnt - CW'(1);
                end else begin
                    cnt_nxt   = CW'(RD_BITS - 1);
                    state_nxt = S_RECV;
                end
            end
            S_RECV: begin
                SS_n = 1'b0;
                if (cnt != '0) cnt_nxt = cnt - CW'(1);
                else           state_nxt = S_END;
            end
            S_END: begin
                resp_valid = is_rd;
                if (is_rd) resp_data = sreg[RD_BITS-1:0];
                // END is itself the first SS_n-high cycle; with GAP=1 it is also the last,
                // so a held cmd_valid goes straight to SEL.
                if (GAP == 1) begin
                    cmd_ready = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = cmd_valid ? S_SEL : S_IDLE;
                end else begin
                    cnt_nxt   = CW'(GAP > 1 ? GAP - 2 : 0);
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                cmd_ready = (cnt == '0);
                if (cnt != '0) cnt_nxt = cnt - CW'(1);
                else           state_nxt = cmd_valid ? S_SEL : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: a table of single frames on two instances
// (TURNAROUND 2 and 4) plus hand sequences for back-to-back and mid-frame reset.
module tb_spi_master_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic       miso = 1'b0;
    int         sel = 0;

    logic       v0, r0, rv0, b0, ss0, mo0;
    logic       v1, r1, rv1, b1, ss1, mo1;
    logic [7:0] rd0, rd1;
    logic       m_ready, m_rv, m_busy, m_ss, m_mosi;
    logic [7:0] m_rd;

    assign v0 = cmd_valid && (sel == 0);
    assign v1 = cmd_valid && (sel != 0);

    always #5 clk = ~clk;

    spi_master_ctrl #(.TURNAROUND(2), .GAP(1), .RD_BITS(8)) dut0 (
        .clk(clk), .rst(rst), .cmd_valid(v0), .cmd_ready(r0), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .resp_valid(rv0), .resp_data(rd0), .busy(b0),
        .SS_n(ss0), .MOSI(mo0), .MISO(miso));

    spi_master_ctrl #(.TURNAROUND(4), .GAP(1), .RD_BITS(8)) dut1 (
        .clk(clk), .rst(rst), .cmd_valid(v1), .cmd_ready(r1), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .resp_valid(rv1), .resp_data(rd1), .busy(b1),
        .SS_n(ss1), .MOSI(mo1), .MISO(miso));

    assign m_ready = (sel != 0) ? r1  : r0;
    assign m_rv    = (sel != 0) ? rv1 : rv0;
    assign m_rd    = (sel != 0) ? rd1 : rd0;
    assign m_busy  = (sel != 0) ? b1  : b0;
    assign m_ss    = (sel != 0) ? ss1 : ss0;
    assign m_mosi  = (sel != 0) ? mo1 : mo0;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        int         s;      // 0: dut0, 1: dut1
        logic [1:0] op;
        logic [7:0] data;
        logic [7:0] miso;   // byte the slave returns during RECV
        int         ta;
        int         len;    // SS_n-low cycles
        logic [11:0] mosi;  // MOSI over SEL, MODE, 10 SHIFT cycles
        logic       rv;
        logic [7:0] resp;
    } vec_t;

    vec_t vecs[8];

    task automatic run_frame(input vec_t v, input string tag);
        int k, w;
        logic [11:0] tr;
        logic tail, rv_low;
        sel = v.s;
        w = 0;
        while (!m_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_ready"}, m_ready, 1);
        cmd_op = v.op; cmd_data = v.data; cmd_valid = 1'b1;
        @(negedge clk);
        k = 0; tr = '0; tail = 1'b0; rv_low = 1'b0;
        while (m_ss == 1'b0 && k < 100) begin
            if (k < 12) tr[11-k] = m_mosi;
            else        tail |= m_mosi;
            rv_low |= m_rv;
            if (k == 5) chk({tag, "_busy"}, m_busy, 1);
            if (k >= 12 + v.ta && k < 20 + v.ta) miso = v.miso[19 + v.ta - k];
            else                                 miso = 1'($urandom);
            // garbage on the command port mid-frame must not disturb the frame
            cmd_valid = (k < 8) ? 1'($urandom) : 1'b0;
            cmd_op    = 2'($urandom);
            cmd_data  = 8'($urandom);
            k++;
            @(negedge clk);
        end
        chk({tag, "_len"},    k, v.len);
        chk({tag, "_mosi"},   tr, v.mosi);
        chk({tag, "_tail0"},  tail, 0);
        chk({tag, "_rvlow"},  rv_low, 0);
        chk({tag, "_rv"},     m_rv, v.rv);
        chk({tag, "_rdata"},  m_rd, v.resp);
        @(negedge clk);
        chk({tag, "_rvpulse"}, m_rv, 0);
    endtask

    initial begin
        int acc, frames, lows, singles;
        logic hist[80];

        vecs[0] = '{0, 2'b00, 8'hA5, 8'h00, 2, 12, 12'h0A5, 1'b0, 8'h00};
        vecs[1] = '{0, 2'b01, 8'h3C, 8'h00, 2, 12, 12'h13C, 1'b0, 8'h00};
        vecs[2] = '{0, 2'b10, 8'hA5, 8'h00, 2, 12, 12'h6A5, 1'b0, 8'h00};
        vecs[3] = '{0, 2'b11, 8'h5A, 8'h3C, 2, 22, 12'h75A, 1'b1, 8'h3C};
        vecs[4] = '{1, 2'b11, 8'hC3, 8'h81, 4, 24, 12'h7C3, 1'b1, 8'h81};
        vecs[5] = '{1, 2'b00, 8'hFF, 8'h00, 4, 12, 12'h0FF, 1'b0, 8'h00};
        vecs[6] = '{0, 2'b11, 8'h00, 8'h00, 2, 22, 12'h700, 1'b1, 8'h00};
        vecs[7] = '{0, 2'b11, 8'hFF, 8'hFF, 2, 22, 12'h7FF, 1'b1, 8'hFF};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_ss",    m_ss, 1);
        chk("rst_mosi",  m_mosi, 0);
        chk("rst_ready", m_ready, 0);
        chk("rst_rv",    m_rv, 0);
        chk("rst_rd",    m_rd, 0);
        chk("rst_busy",  m_busy, 1);
        rst = 1'b0;
        #1 chk("rel_ready0", m_ready, 0);
        @(negedge clk);
        chk("rel_ready1", m_ready, 1);
        chk("rel_busy0",  m_busy, 0);

        for (int i = 0; i < 4; i++) run_frame(vecs[i], $sformatf("v%0d", i));

        // back-to-back with cmd_valid held high
        sel = 0; acc = 0; cmd_valid = 1'b1;
        for (int c = 0; c < 80; c++) begin
            if (acc == 3) cmd_valid = 1'b0;
            else begin
                cmd_op   = acc[1:0];
                cmd_data = 8'(acc);
            end
            hist[c] = m_ss;
            if (cmd_valid && m_ready) acc++;
            @(negedge clk);
        end
        frames = 0; lows = 0; singles = 0;
        for (int c = 1; c < 80; c++) begin
            if (hist[c] == 1'b0) lows++;
            if (hist[c] == 1'b0 && hist[c-1] == 1'b1) begin
                frames++;
                if (c >= 2 && hist[c-2] == 1'b0) singles++;
            end
        end
        chk("b2b_accepts", acc, 3);
        chk("b2b_frames",  frames, 3);
        chk("b2b_lows",    lows, 36);
        chk("b2b_gap1",    singles, 2);

        // reset pulsed at SHIFT bit 5 of a read-data frame
        sel = 0;
        cmd_op = 2'b11; cmd_data = 8'h5A; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("midrst_pre_ss", m_ss, 0);
        rst = 1'b1;
        #1;
        chk("midrst_ss",    m_ss, 1);
        chk("midrst_rv",    m_rv, 0);
        chk("midrst_ready", m_ready, 0);
        @(negedge clk);
        chk("midrst_rv2", m_rv, 0);
        rst = 1'b0;
        run_frame(vecs[3], "post_rst");

        for (int i = 4; i < 8; i++) run_frame(vecs[i], $sformatf("v%0d", i));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
